// File: rtl/and_seq_pkg.sv
// Shared definitions for the gate test sequencers.
//   state_t   : sequencer FSM encoding
//   CNT_W_DEF : default width of the loop and error counters
//   VEC_W     : width of the stimulus vector {a,b}
package and_seq_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int VEC_W     = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/and_test_sequencer_if.sv
// Control/status and DUT-stimulus bundle of the gate test sequencer.
//   master : test controller side (drives start/abort/loops, returns dut_out)
//   slave  : sequencer side (drives stimulus and status)
interface and_test_sequencer_if
    import and_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] loops;
    logic             dut_a;
    logic             dut_b;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic             fail_valid;
    logic [VEC_W-1:0] fail_vec;

    modport master (
        output start, abort, loops, dut_out,
        input  dut_a, dut_b, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, abort, loops, dut_out,
        output dut_a, dut_b, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/and_ref_model.sv
// Expected-value model for a 2-input AND under test.
//   a, b : applied stimulus
//   y    : expected DUT output
module and_ref_model (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/and_test_sequencer.sv
// Exhaustive sweep tester for a 2-input gate: applies all four {a,b}
// vectors per loop, waits SETTLE_CYCLES, compares against the reference
// model and accumulates a saturating error count plus the first failing vector.
//   clk, rst : clock, synchronous active-high reset
//   bus      : control, status and DUT stimulus (slave side)
module and_test_sequencer
    import and_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    and_test_sequencer_if.slave  bus
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] dut_q, dut_d;
    logic [CNT_W-1:0] sweep_q, sweep_d;   // sweeps remaining, including the current one
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             expected;
    logic             running;

    and_ref_model u_ref (
        .a (vec_q[1]),
        .b (vec_q[0]),
        .y (expected)
    );

    assign running = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        dut_d        = dut_q;
        sweep_d      = sweep_q;
        settle_d     = settle_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        pass_d       = pass_q;
        done_d       = 1'b0;

        if (bus.abort && running) begin
            // Aborted runs keep their error evidence but never report a pass.
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        vec_d        = '0;
                        sweep_d      = bus.loops;
                        err_d        = '0;
                        fail_valid_d = 1'b0;
                        fail_vec_d   = '0;
                        pass_d       = 1'b0;
                        state_d      = (bus.loops == '0) ? S_DONE : S_APPLY;
                    end
                end
                S_APPLY: begin
                    dut_d    = vec_q;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_d = S_CHECK;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                S_CHECK: begin
                    if (bus.dut_out != expected) begin
                        if (err_q != '1) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = vec_q;
                        end
                    end
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = S_APPLY;
                    if (vec_q == '1) begin
                        if (sweep_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            sweep_d = sweep_q - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Stimulus is parked at 0 whenever the sequencer is idle.
        if (state_d == S_IDLE) begin
            dut_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            dut_q        <= '0;
            sweep_q      <= '0;
            settle_q     <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            dut_q        <= dut_d;
            sweep_q      <= sweep_d;
            settle_q     <= settle_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    assign bus.dut_a      = dut_q[1];
    assign bus.dut_b      = dut_q[0];
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;
endmodule

// File: tb/tb_and_test_sequencer.sv
module tb_and_test_sequencer;
    localparam int S  = 1;
    localparam int CW = 8;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    and_test_sequencer_if #(.CNT_W(CW)) bus ();

    and_test_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gate under test: 0 = good AND, 1 = stuck-at-1, 2 = stuck-at-0
    int mode = 0;
    always_comb begin
        bus.dut_out = bus.dut_a & bus.dut_b;
        if (mode == 1) bus.dut_out = 1'b1;
        else if (mode == 2) bus.dut_out = 1'b0;
    end

    typedef struct {
        int lat;
        int err;
        int pass;
        int fv;
        int fvec;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input int m, input int l);
        exp_t e;
        e.err = 0; e.fv = 0; e.fvec = 0;
        for (int s = 0; s < l; s++) begin
            for (int v = 0; v < 4; v++) begin
                int want, got;
                want = (v >> 1) & v & 1;
                got  = (m == 1) ? 1 : (m == 2) ? 0 : want;
                if (got != want) begin
                    if (e.err < SAT) e.err++;
                    if (e.fv == 0) begin e.fv = 1; e.fvec = v; end
                end
            end
        end
        e.lat  = 4 * l * (S + 2) + 1;
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic do_start(input int l);
        @(negedge clk);
        bus.loops = CW'(l);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " done"}, bus.done, 0);
        check({tag, " pass"}, bus.pass, 0);
        check({tag, " err"}, bus.err_count, 0);
        check({tag, " fail_valid"}, bus.fail_valid, 0);
        check({tag, " fail_vec"}, bus.fail_vec, 0);
        check({tag, " dut_ab"}, {bus.dut_a, bus.dut_b}, 0);
    endtask

    // Full run: wait for done with a cycle budget, optionally pulsing start mid-run.
    task automatic run(input string tag, input int m, input int l, input int poke);
        exp_t e;
        int cyc;
        bit nz;
        mode = m;
        sb.push_back(predict(m, l));
        do_start(l);
        check({tag, " busy"}, bus.busy, 1);
        cyc = 0;
        nz  = 0;
        while (cyc < 5000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.dut_a || bus.dut_b) nz = 1;
            if (bus.done) break;
            bus.start = (cyc == poke);
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        check({tag, " done_latency"}, cyc, e.lat);
        check({tag, " err"}, bus.err_count, e.err);
        check({tag, " pass"}, bus.pass, e.pass);
        check({tag, " fail_valid"}, bus.fail_valid, e.fv);
        if (e.fv != 0) check({tag, " fail_vec"}, bus.fail_vec, e.fvec);
        if (l == 0) check({tag, " dut_stayed_0"}, nz, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_1cyc"}, bus.done, 0);
        check({tag, " idle"}, bus.busy, 0);
        check({tag, " pass_hold"}, bus.pass, e.pass);
        check({tag, " err_hold"}, bus.err_count, e.err);
        check({tag, " dut_idle0"}, {bus.dut_a, bus.dut_b}, 0);
    endtask

    initial begin
        exp_t e;
        bit seen;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.loops = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        run("good_l1", 0, 1, -1);
        run("sa1_l1", 1, 1, -1);
        run("sa0_l5", 2, 5, -1);
        run("sa1_l255_sat", 1, 255, -1);
        run("loops0", 0, 0, -1);
        run("good_l2_start_while_busy", 0, 2, 5);

        // Abort in SETTLE of the second sweep; evidence from sweep 1 is kept.
        mode = 1;
        sb.push_back('{lat: 0, err: 3, pass: 0, fv: 1, fvec: 0});
        do_start(2);
        repeat (13) begin @(posedge clk); @(negedge clk); end
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort idle_next", bus.busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        e = sb.pop_front();
        check("abort no_done", seen, 0);
        check("abort err", bus.err_count, e.err);
        check("abort pass", bus.pass, e.pass);
        check("abort fail_valid", bus.fail_valid, e.fv);
        check("abort fail_vec", bus.fail_vec, e.fvec);

        // start together with abort in IDLE must not launch a run.
        @(negedge clk);
        bus.loops = CW'(1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort idle", bus.busy, 0);
        check("start_abort err_kept", bus.err_count, 3);

        // Reset in SETTLE of vector 1, after vector 0 already failed.
        mode = 1;
        do_start(1);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        check("pre_rst err", bus.err_count, 1);
        check("pre_rst busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        run("post_rst_good", 0, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/and_test_sequencer.md
AND_TEST_SEQUENCER -- requirements
Module: and_test_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock and reset ports are named clk and rst.
REQ-002 Parameter SETTLE_CYCLES, default 1, SHALL set the number of cycles (min 1) each vector is held before its output is sampled.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of loops and err_count.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin a test run; sampled only in IDLE.
REQ-007 abort  input  1  terminate a run in progress.
REQ-008 loops  input  CNT_W  number of full 4-vector sweeps; latched on start.
REQ-009 dut_a, dut_b  output  1 each  registered stimulus to the 2-input AND under test.
REQ-010 dut_out  input  1  DUT output.
REQ-011 busy  output  1  high from the cycle after start is accepted until DONE is exited.
REQ-012 done  output  1  one-cycle pulse at normal completion.
REQ-013 pass  output  1  high when the last completed run had err_count==0.
REQ-014 err_count  output  CNT_W  mismatches in the current or last run.
REQ-015 fail_valid, fail_vec  output  1, 2  first failing vector {a,b} and its valid flag.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-017 In IDLE, start=1 with abort=0 SHALL latch loops, set vec=0, clear err_count, fail_valid and pass, and go to APPLY; if loops==0, it SHALL go directly to DONE.
REQ-018 APPLY SHALL drive {dut_a,dut_b}=vec for one cycle and then go to SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to CHECK.
REQ-020 CHECK SHALL compare dut_out to (vec[1] & vec[0]); a mismatch SHALL increment err_count, saturating at all-ones.
REQ-021 On the first mismatch of a run, CHECK SHALL set fail_valid=1 and fail_vec=vec; later mismatches SHALL NOT overwrite them.
REQ-022 After CHECK, vec SHALL increment modulo 4, and the state SHALL go to APPLY, except when vec==3 on the final sweep, in which case it SHALL go to DONE.
REQ-023 DONE SHALL last one cycle: done=1 and pass=(err_count==0); it SHALL then go to IDLE.
REQ-024 With loops=L>0, done SHALL assert exactly 4*L*(SETTLE_CYCLES+2)+1 cycles after the clock edge that accepted start.
REQ-025 dut_a and dut_b SHALL hold the last applied vector while the FSM is in SETTLE, CHECK and DONE, and SHALL return to 0 in IDLE.
REQ-026 start while busy SHALL be ignored.
REQ-027 abort in APPLY, SETTLE or CHECK SHALL return the FSM to IDLE on the next cycle, without a done pulse, with pass=0, and with err_count and fail_* retained.
REQ-028 abort and start together in IDLE SHALL leave the FSM in IDLE.
REQ-029 pass, err_count and fail_* SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 rst SHALL force the FSM to IDLE, take priority over all other inputs, and apply in any state, including mid-run.
REQ-031 Reset values SHALL be: dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, and all internal vector, sweep and settle counters 0.

Structure
REQ-032 A shared package and_seq_pkg SHALL hold the state encoding, the default CNT_W, and the vector width constant (2).
REQ-033 The expected-value function SHALL be a sub-module and_ref_model (combinational a&b), so that other gate sequencers can substitute their own model.
REQ-034 The sweep counter, settle counter and error counter SHALL be registers inside and_test_sequencer.

Verification
REQ-035 Correct AND DUT, SETTLE_CYCLES=1, loops=1 -> done pulses 13 cycles after start, pass=1, err_count=0, fail_valid=0.
REQ-036 DUT stuck-at-1, loops=1 -> err_count=3, fail_vec=2'b00, fail_valid=1, pass=0.
REQ-037 DUT stuck-at-0, loops=5 -> err_count=5, fail_vec=2'b11; DUT stuck-at-1 with loops=255 -> err_count saturates at 255.
REQ-038 loops=0 -> done on the second cycle after start, pass=1, and dut_a/dut_b never leave 0.
REQ-039 Abort during the 2nd sweep -> FSM in IDLE next cycle, no done pulse, pass=0; a start pulse while busy has no effect on the done timing.
REQ-040 rst asserted mid-run in SETTLE -> all outputs at reset values on the next cycle, and a new start runs normally.
